// File: rtl/motor_dir_sequencer_if.sv
// Avalon-MM slave register bus used by motor_dir_sequencer.
//   address     2-bit word address
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   32-bit write data
//   readdata    32-bit read data, combinational from address
interface motor_dir_sequencer_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input  readdata);
   modport slave  (input  address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/motor_dir_sequencer.sv
// Two-motor H-bridge direction sequencer with shoot-through protection.
// Software writes a target direction code per motor. Each motor FSM applies the
// change to out_port. A direct move between two different driven codes first
// coasts (00) for DEAD+1 cycles.
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   bus       Avalon-MM slave (TARGET @0, DEAD @1, STATUS @2, reserved @3)
//   out_port  driver pins, [1:0] motor0, [3:2] motor1; code 00 coast/01 fwd/10 rev/11 brake

// Per-motor direction FSM.
//   tgt   target code (registered TARGET slice)
//   dead  dead-time cycles, sampled when a coast interval starts
//   out   driven code
//   busy  high while coasting between two driven codes
module motor_dir_fsm #(
   parameter int DEAD_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        tgt,
   input  logic [DEAD_W-1:0] dead,
   output logic [1:0]        out,
   output logic              busy
);
   typedef enum logic {ST_STABLE, ST_DEAD} state_t;

   state_t            state_q, state_d;
   logic [1:0]        out_q, out_d;
   logic [DEAD_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_STABLE;
         out_q   <= 2'b00;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_STABLE: begin
            if (out_q != tgt) begin
               if (out_q == 2'b00 || tgt == 2'b00) begin
                  out_d = tgt;
               end else begin
                  // Driven-to-driven change: coast first. The count is latched
                  // here so later DEAD writes only affect the next interval.
                  out_d   = 2'b00;
                  cnt_d   = dead;
                  state_d = ST_DEAD;
               end
            end
         end
         ST_DEAD: begin
            if (tgt == 2'b00) begin
               state_d = ST_STABLE;
            end else if (cnt_q == '0) begin
               // Outputs are already 00, so whatever the target is now can be
               // applied directly without another coast.
               out_d   = tgt;
               state_d = ST_STABLE;
            end else begin
               cnt_d = cnt_q - DEAD_W'(1);
            end
         end
         default: state_d = ST_STABLE;
      endcase
   end

   assign out  = out_q;
   assign busy = (state_q == ST_DEAD);
endmodule

module motor_dir_sequencer #(
   parameter int DEAD_W       = 16,
   parameter int DEAD_DEFAULT = 50000
) (
   input  logic                   clk,
   input  logic                   reset_n,
   motor_dir_sequencer_if.slave   bus,
   output logic [3:0]             out_port
);
   localparam int NUM_MOTORS = 2;

   logic [3:0]            target_q;
   logic [DEAD_W-1:0]     dead_q;
   logic [NUM_MOTORS-1:0] busy;
   logic                  wr_en;

   assign wr_en = bus.chipselect & ~bus.write_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         target_q <= 4'h0;
         dead_q   <= DEAD_W'(DEAD_DEFAULT);
      end else if (wr_en) begin
         case (bus.address)
            2'd0:    target_q <= bus.writedata[3:0];
            2'd1:    dead_q   <= bus.writedata[DEAD_W-1:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.readdata = 32'h0;
      case (bus.address)
         2'd0:    bus.readdata = {28'h0, target_q};
         2'd1:    bus.readdata = 32'(dead_q);
         2'd2:    bus.readdata = {26'h0, busy, out_port};
         default: bus.readdata = 32'h0;
      endcase
   end

   // The FSMs read target_q, so a TARGET write acts one cycle after it lands.
   for (genvar m = 0; m < NUM_MOTORS; m++) begin : g_motor
      motor_dir_fsm #(.DEAD_W(DEAD_W)) u_fsm (
         .clk     (clk),
         .reset_n (reset_n),
         .tgt     (target_q[2*m +: 2]),
         .dead    (dead_q),
         .out     (out_port[2*m +: 2]),
         .busy    (busy[m])
      );
   end

   logic unused_wdata;
   assign unused_wdata = &{1'b0, bus.writedata[31:DEAD_W]};
endmodule

// File: tb/tb_motor_dir_sequencer.sv
module tb_motor_dir_sequencer;
   logic       clk;
   logic       reset_n;
   logic [3:0] out_port;
   int         n_pass;
   int         n_total;

   motor_dir_sequencer_if bus ();

   motor_dir_sequencer dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .out_port (out_port)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present a write for one rising edge; returns 1 ns after that edge.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      @(posedge clk);
      #1;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      bus.address = a;
      #1;
      d = bus.readdata;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset_n = 1'b0;
      bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      step();
      n_total++; if (out_port !== 4'h0) $display("FAIL reset_out got=%h exp=0", out_port); else n_pass++;
      rd(2'd0, d);
      n_total++; if (d !== 32'd0) $display("FAIL reset_target got=%0d exp=0", d); else n_pass++;
      rd(2'd1, d);
      n_total++; if (d !== 32'd50000) $display("FAIL reset_dead got=%0d exp=50000", d); else n_pass++;
      rd(2'd2, d);
      n_total++; if (d !== 32'd0) $display("FAIL reset_status got=%h exp=0", d); else n_pass++;
      rd(2'd3, d);
      n_total++; if (d !== 32'd0) $display("FAIL reset_rsvd got=%h exp=0", d); else n_pass++;
   endtask

   task automatic test_direct();
      logic [31:0] d;
      wr(2'd0, 32'h1);
      // TARGET is visible now; the output follows one edge later.
      rd(2'd0, d);
      n_total++; if (d !== 32'h1) $display("FAIL direct_tgt_rb got=%h exp=1", d); else n_pass++;
      n_total++; if (out_port !== 4'h0) $display("FAIL direct_early got=%h exp=0", out_port); else n_pass++;
      step();
      rd(2'd2, d);
      n_total++; if (d !== 32'h1) $display("FAIL direct_status got=%h exp=01", d); else n_pass++;
   endtask

   task automatic test_coast();
      logic [31:0] d;
      wr(2'd1, 32'd3);
      rd(2'd1, d);
      n_total++; if (d !== 32'd3) $display("FAIL dead_rb got=%0d exp=3", d); else n_pass++;
      wr(2'd0, 32'h2);
      n_total++; if (out_port !== 4'h1) $display("FAIL coast_pre got=%h exp=1", out_port); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         step();
         rd(2'd2, d);
         n_total++; if (d !== 32'h10) $display("FAIL coast_c%0d status got=%h exp=10", i, d); else n_pass++;
      end
      step();
      rd(2'd2, d);
      n_total++; if (d !== 32'h02) $display("FAIL coast_end status got=%h exp=02", d); else n_pass++;
   endtask

   task automatic test_independent();
      wr(2'd0, 32'h0);
      step();
      n_total++; if (out_port !== 4'h0) $display("FAIL indep_clear got=%h exp=0", out_port); else n_pass++;
      wr(2'd0, 32'h1);
      step();
      n_total++; if (out_port !== 4'h1) $display("FAIL indep_fwd got=%h exp=1", out_port); else n_pass++;
      // m1 00->11 direct, m0 01->10 coasts 4 cycles
      wr(2'd0, 32'hE);
      for (int i = 0; i < 4; i++) begin
         step();
         n_total++; if (out_port !== 4'hC) $display("FAIL indep_c%0d got=%h exp=c", i, out_port); else n_pass++;
      end
      step();
      n_total++; if (out_port !== 4'hE) $display("FAIL indep_end got=%h exp=e", out_port); else n_pass++;
   endtask

   task automatic test_mid_dead_writes();
      logic [31:0] d;
      // DEAD rewrite during a coast leaves the running count alone.
      wr(2'd0, 32'hD);
      step();                                    // E1: coast starts
      n_total++; if (out_port !== 4'hC) $display("FAIL middead_c0 got=%h exp=c", out_port); else n_pass++;
      wr(2'd1, 32'd10);                          // E2
      n_total++; if (out_port !== 4'hC) $display("FAIL middead_c1 got=%h exp=c", out_port); else n_pass++;
      step();                                    // E3
      step();                                    // E4
      n_total++; if (out_port !== 4'hC) $display("FAIL middead_c3 got=%h exp=c", out_port); else n_pass++;
      step();                                    // E5
      n_total++; if (out_port !== 4'hD) $display("FAIL middead_end got=%h exp=d", out_port); else n_pass++;
      rd(2'd1, d);
      n_total++; if (d !== 32'd10) $display("FAIL middead_dead_rb got=%0d exp=10", d); else n_pass++;
      // Target 00 mid-coast releases busy the cycle after it is seen.
      wr(2'd0, 32'hE);
      step();
      rd(2'd2, d);
      n_total++; if (d !== 32'h1C) $display("FAIL abort_busy got=%h exp=1c", d); else n_pass++;
      wr(2'd0, 32'hC);
      rd(2'd2, d);
      n_total++; if (d !== 32'h1C) $display("FAIL abort_old_tgt got=%h exp=1c", d); else n_pass++;
      step();
      rd(2'd2, d);
      n_total++; if (d !== 32'h0C) $display("FAIL abort_clear got=%h exp=0c", d); else n_pass++;
      step();
      n_total++; if (out_port !== 4'hC) $display("FAIL abort_hold got=%h exp=c", out_port); else n_pass++;
   endtask

   task automatic test_ignored_writes();
      logic [31:0] d;
      wr(2'd2, 32'hFFFF_FFFF);
      wr(2'd3, 32'hFFFF_FFFF);
      rd(2'd2, d);
      n_total++; if (d !== 32'h0C) $display("FAIL ro_status got=%h exp=0c", d); else n_pass++;
      rd(2'd3, d);
      n_total++; if (d !== 32'h0) $display("FAIL rsvd_rd got=%h exp=0", d); else n_pass++;
      rd(2'd0, d);
      n_total++; if (d !== 32'hC) $display("FAIL ro_target got=%h exp=c", d); else n_pass++;
   endtask

   task automatic test_reset_mid_dead();
      logic [31:0] d;
      wr(2'd0, 32'hD);
      step();
      n_total++; if (out_port !== 4'hD) $display("FAIL rmd_pre got=%h exp=d", out_port); else n_pass++;
      wr(2'd0, 32'hE);
      step();
      rd(2'd2, d);
      n_total++; if (d !== 32'h1C) $display("FAIL rmd_busy got=%h exp=1c", d); else n_pass++;
      #1;
      reset_n = 1'b0;
      #1;
      n_total++; if (out_port !== 4'h0) $display("FAIL rmd_async got=%h exp=0", out_port); else n_pass++;
      @(negedge clk);
      reset_n = 1'b1;
      step();
      rd(2'd0, d);
      n_total++; if (d !== 32'h0) $display("FAIL rmd_target got=%h exp=0", d); else n_pass++;
      rd(2'd2, d);
      n_total++; if (d !== 32'h0) $display("FAIL rmd_status got=%h exp=0", d); else n_pass++;
      rd(2'd1, d);
      n_total++; if (d !== 32'd50000) $display("FAIL rmd_dead got=%0d exp=50000", d); else n_pass++;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_direct();
      test_coast();
      test_independent();
      test_mid_dead_writes();
      test_ignored_writes();
      test_reset_mid_dead();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
